// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer feeding the TX_mux: start, 8 data bits LSB first, parity, stop.
// All mux controls come straight from flops so the serial line never glitches.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [1:0] sel,
  output logic       startbit,
  output logic       databit,
  output logic       paritybit,
  output logic       stopbit
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_TC = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  function automatic logic parity_of(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [1:0]    sel_q, sel_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          baud_tc_s;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    done_d    = 1'b0;
    baud_tc_s = (baud_q == BAUD_TC);

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          shift_d = tx_data;
          par_d   = parity_of(tx_data, PARITY_ODD);
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (baud_tc_s) state_d = S_DATA;
        else           state_d = S_START;
      end
      S_DATA: begin
        if (baud_tc_s) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_PARITY;
          else               state_d = S_DATA;
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (baud_tc_s) state_d = S_STOP;
        else           state_d = S_PARITY;
      end
      S_STOP: begin
        if (baud_tc_s) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Baud count restarts on every bit boundary, including bit-to-bit inside DATA
    if (state_q == S_IDLE || baud_tc_s || state_d != state_q) begin
      baud_d = {CW{1'b0}};
    end else begin
      baud_d = baud_q + {{(CW-1){1'b0}}, 1'b1};
    end

    case (state_d)
      S_START:  sel_d = 2'b00;
      S_DATA:   sel_d = 2'b01;
      S_PARITY: sel_d = 2'b10;
      default:  sel_d = 2'b11;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= {CW{1'b0}};
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      par_q   <= 1'b0;
      sel_q   <= 2'b11;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx_busy   = busy_q;
  assign tx_done   = done_q;
  assign sel       = sel_q;
  assign startbit  = 1'b0;
  assign databit   = shift_q[0];
  assign paritybit = par_q;
  assign stopbit   = 1'b1;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench: expected frame bits are queued at acceptance and compared per cycle.
// Instance A: N=16 even parity; instance B: N=4 odd parity.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b;
  logic [7:0] data_a, data_b;
  logic       busy_a, done_a, sb_a, db_a, pb_a, stb_a;
  logic       busy_b, done_b, sb_b, db_b, pb_b, stb_b;
  logic [1:0] sel_a, sel_b;

  int total = 0;
  int passed = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  bit which = 1'b0;
  logic [2:0] q[$];

  always #5 clk = ~clk;

  uart_tx_ctrl #(.CLKS_PER_BIT(16), .PARITY_ODD(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_start(start_a), .tx_data(data_a),
    .tx_busy(busy_a), .tx_done(done_a), .sel(sel_a), .startbit(sb_a),
    .databit(db_a), .paritybit(pb_a), .stopbit(stb_a));

  uart_tx_ctrl #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_start(start_b), .tx_data(data_b),
    .tx_busy(busy_b), .tx_done(done_b), .sel(sel_b), .startbit(sb_b),
    .databit(db_b), .paritybit(pb_b), .stopbit(stb_b));

  always @(posedge clk) begin
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  end

  function automatic logic tx_mux(input logic [1:0] s, input logic st, input logic d,
                                  input logic p, input logic sp);
    case (s)
      2'b00:   return st;
      2'b01:   return d;
      2'b10:   return p;
      default: return sp;
    endcase
  endfunction

  logic [1:0] o_sel;
  logic o_busy, o_done, o_sb, o_db, o_pb, o_stb, o_txd;
  always_comb begin
    o_sel  = which ? sel_b  : sel_a;
    o_busy = which ? busy_b : busy_a;
    o_done = which ? done_b : done_a;
    o_sb   = which ? sb_b   : sb_a;
    o_db   = which ? db_b   : db_a;
    o_pb   = which ? pb_b   : pb_a;
    o_stb  = which ? stb_b  : stb_a;
    o_txd  = tx_mux(o_sel, o_sb, o_db, o_pb, o_stb);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s (inst %0d): observed %h expected %h", tag, which, obs, exp);
  endtask

  task automatic drive_start(input logic v, input logic [7:0] d);
    if (which) begin start_b = v; data_b = d; end
    else       begin start_a = v; data_a = d; end
  endtask

  // Called at a negedge: request the byte and queue its expected line bits
  task automatic start_frame(input logic [7:0] d);
    logic odd;
    odd = which;
    drive_start(1'b1, d);
    q.push_back({2'b00, 1'b0});
    for (int i = 0; i < 8; i++) q.push_back({2'b01, d[i]});
    q.push_back({2'b10, (^d) ^ odd});
    q.push_back({2'b11, 1'b1});
  endtask

  task automatic run_frame(input int inj_at, input logic [7:0] inj_d, input bit chain,
                           input logic [7:0] next_d, input int abort_at);
    int n;
    logic [2:0] e;
    n = which ? 4 : 16;
    for (int c = 0; c < 11 * n; c++) begin
      @(negedge clk);
      if (c == 0) drive_start(1'b0, 8'h00);
      if (c == inj_at) drive_start(1'b1, inj_d);
      if (c == inj_at + 1) drive_start(1'b0, 8'h00);
      if (c == abort_at) return;
      if (q.size() == 0) begin
        chk("queue_empty", 8'd1, 8'd0);
        return;
      end
      e = q[0];
      chk("busy", {7'd0, o_busy}, 8'd1);
      chk("done_in_frame", {7'd0, o_done}, 8'd0);
      chk("sel", {6'd0, o_sel}, {6'd0, e[2:1]});
      chk("txdata", {7'd0, o_txd}, {7'd0, e[0]});
      if (e[2:1] == 2'b10) chk("paritybit", {7'd0, o_pb}, {7'd0, e[0]});
      if (c % n == n - 1) void'(q.pop_front());
    end
    @(negedge clk);
    chk("done_pulse", {7'd0, o_done}, 8'd1);
    chk("busy_at_done", {7'd0, o_busy}, 8'd0);
    chk("sel_at_done", {6'd0, o_sel}, 8'd3);
    chk("txdata_at_done", {7'd0, o_txd}, 8'd1);
    if (chain) begin
      start_frame(next_d);
    end else begin
      drive_start(1'b0, 8'h00);
      @(negedge clk);
      chk("done_cleared", {7'd0, o_done}, 8'd0);
      chk("idle_line", {7'd0, o_txd}, 8'd1);
    end
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; data_a = 8'h00; data_b = 8'h00;
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      which = w[0];
      #1;
      chk("rst_sel", {6'd0, o_sel}, 8'd3);
      chk("rst_busy", {7'd0, o_busy}, 8'd0);
      chk("rst_done", {7'd0, o_done}, 8'd0);
      chk("rst_databit", {7'd0, o_db}, 8'd0);
      chk("rst_paritybit", {7'd0, o_pb}, 8'd0);
      chk("startbit_const", {7'd0, o_sb}, 8'd0);
      chk("stopbit_const", {7'd0, o_stb}, 8'd1);
    end
    which = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_sel", {6'd0, o_sel}, 8'd3);
    chk("idle_txdata", {7'd0, o_txd}, 8'd1);
    chk("idle_busy", {7'd0, o_busy}, 8'd0);

    // Plain 0xA5 frame
    base = done_cnt_a;
    start_frame(8'hA5);
    run_frame(-10, 8'h00, 1'b0, 8'h00, -1);
    chk("done_count_a5", 8'(done_cnt_a - base), 8'd1);

    // Start request mid-frame must be ignored
    base = done_cnt_a;
    start_frame(8'hA5);
    run_frame(39, 8'h3C, 1'b0, 8'h00, -1);
    chk("done_count_ignored", 8'(done_cnt_a - base), 8'd1);
    chk("busy_after_ignored", {7'd0, o_busy}, 8'd0);

    // Back-to-back frames: start in the done cycle
    base = done_cnt_a;
    start_frame(8'hFF);
    run_frame(-10, 8'h00, 1'b1, 8'h5A, -1);
    run_frame(-10, 8'h00, 1'b0, 8'h00, -1);
    chk("done_count_b2b", 8'(done_cnt_a - base), 8'd2);

    // Reset during data bit 3 of 0x81
    base = done_cnt_a;
    start_frame(8'h81);
    run_frame(-10, 8'h00, 1'b0, 8'h00, 69);
    rst_n = 1'b0;
    #1;
    chk("midrst_sel", {6'd0, o_sel}, 8'd3);
    chk("midrst_busy", {7'd0, o_busy}, 8'd0);
    chk("midrst_done", {7'd0, o_done}, 8'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("postrst_sel", {6'd0, o_sel}, 8'd3);
      chk("postrst_done", {7'd0, o_done}, 8'd0);
      chk("postrst_busy", {7'd0, o_busy}, 8'd0);
    end
    chk("done_count_aborted", 8'(done_cnt_a - base), 8'd0);
    start_frame(8'h81);
    run_frame(-10, 8'h00, 1'b0, 8'h00, -1);
    chk("done_count_resend", 8'(done_cnt_a - base), 8'd1);

    // Odd-parity instance
    which = 1'b1;
    base = done_cnt_b;
    start_frame(8'h00);
    run_frame(-10, 8'h00, 1'b0, 8'h00, -1);
    start_frame(8'h07);
    run_frame(-10, 8'h00, 1'b0, 8'h00, -1);
    chk("done_count_odd", 8'(done_cnt_b - base), 8'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
